vga_sync: RTL

VGA 640x480 timing generator for the game console display path. It divides the board clock down to the pixel rate and runs the horizontal/vertical counters. It drives the HS/VS pins and supplies Coloana, Linie, InDisplay and VS to every screen renderer (death screen, game screen, menu). Its counter ranges define the coordinate space the renderers decode: visible columns 144..783, visible lines 32..511.

---
 rtl/vga_sync.sv | 86 ++++++++
 1 files changed

// File: rtl/vga_sync.sv
// VGA timing generator: divides the board clock to the pixel rate and runs the
// horizontal/vertical counters, producing registered sync, visible-area and frame-start strobes.
module vga_sync #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_VIS_MIN = 144,
    parameter int unsigned H_VIS_MAX = 783,
    parameter int unsigned H_TOTAL   = 800,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_VIS_MIN = 32,
    parameter int unsigned V_VIS_MAX = 511,
    parameter int unsigned V_TOTAL   = 521
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] Coloana,
    output logic [9:0] Linie,
    output logic       HS,
    output logic       VS,
    output logic       InDisplay,
    output logic       frame_start
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_END   = 10'(H_SYNC);
    localparam logic [9:0] VS_END   = 10'(V_SYNC);
    localparam logic [9:0] HV_MIN   = 10'(H_VIS_MIN);
    localparam logic [9:0] HV_MAX   = 10'(H_VIS_MAX);
    localparam logic [9:0] VV_MIN   = 10'(V_VIS_MIN);
    localparam logic [9:0] VV_MAX   = 10'(V_VIS_MAX);

    logic [3:0] div;
    logic [3:0] div_n;
    logic [9:0] col_n;
    logic [9:0] lin_n;
    logic       wrap_frame;

    always_comb begin
        div_n      = (div == DIV_LAST) ? '0 : div + 4'd1;
        col_n      = Coloana;
        lin_n      = Linie;
        wrap_frame = 1'b0;
        if (pix_en) begin
            if (Coloana == H_LAST) begin
                col_n = '0;
                if (Linie == V_LAST) begin
                    lin_n      = '0;
                    wrap_frame = 1'b1;
                end else begin
                    lin_n = Linie + 10'd1;
                end
            end else begin
                col_n = Coloana + 10'd1;
            end
        end
    end

    // Strobes are decoded from the next-state counts so they line up with the
    // Coloana/Linie values presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            div         <= '0;
            pix_en      <= 1'b0;
            Coloana     <= '0;
            Linie       <= '0;
            HS          <= 1'b0;
            VS          <= 1'b0;
            InDisplay   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= div_n;
            pix_en      <= (div_n == DIV_LAST);
            Coloana     <= col_n;
            Linie       <= lin_n;
            HS          <= (col_n >= HS_END);
            VS          <= (lin_n >= VS_END);
            InDisplay   <= (col_n >= HV_MIN) && (col_n <= HV_MAX) &&
                           (lin_n >= VV_MIN) && (lin_n <= VV_MAX);
            frame_start <= wrap_frame;
        end
    end

endmodule
